// File: rtl/pm_pkg.sv
// Shared power-management types: idle monitor state encoding and default thresholds.
package pm_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'b00,
        ST_COUNTING = 2'b01,
        ST_IDLE     = 2'b10,
        ST_DEEP     = 2'b11
    } idle_state_t;

    localparam int DEF_IDLE_THRESH = 8;
    localparam int DEF_DEEP_THRESH = 32;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count     = count_q;
    // Exposed so the FSM can decide on the value this edge will load.
    assign count_nxt = count_d;

endmodule

// File: rtl/idle_monitor.sv
// Detects sustained quiet periods and drives idle/interrupt into power_management;
// pulses wake_pulse when leaving the prolonged-idle state.
module idle_monitor
    import pm_pkg::*;
#(
    parameter int IDLE_THRESH = DEF_IDLE_THRESH,
    parameter int DEEP_THRESH = DEF_DEEP_THRESH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             activity,
    input  logic             wake_req,
    input  logic             pg_down,
    output logic             idle,
    output logic             interrupt,
    output logic             wake_pulse,
    output logic [CNT_W-1:0] idle_cnt,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] IDLE_T = CNT_W'(IDLE_THRESH);
    localparam logic [CNT_W-1:0] DEEP_T = CNT_W'(DEEP_THRESH);

    idle_state_t      state_q, state_d;
    logic             idle_q, interrupt_q, wake_pulse_q;
    logic             ev;
    logic [CNT_W-1:0] cnt_nxt;

    // Activity is meaningless while the power domain is down; only wake_req can exit then.
    assign ev = wake_req | (activity & ~pg_down);

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (ev),
        .inc       (~ev),
        .count     (idle_cnt),
        .count_nxt (cnt_nxt)
    );

    always_comb begin
        state_d = state_q;
        if (ev) begin
            state_d = ST_ACTIVE;
        end else begin
            unique case (state_q)
                ST_ACTIVE:   state_d = (cnt_nxt == IDLE_T) ? ST_IDLE : ST_COUNTING;
                ST_COUNTING: if (cnt_nxt == IDLE_T) state_d = ST_IDLE;
                ST_IDLE:     if (cnt_nxt == DEEP_T) state_d = ST_DEEP;
                ST_DEEP:     state_d = ST_DEEP;
                default:     state_d = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_ACTIVE;
            idle_q       <= 1'b0;
            interrupt_q  <= 1'b0;
            wake_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_q       <= (state_d == ST_IDLE) || (state_d == ST_DEEP);
            interrupt_q  <= (state_d == ST_DEEP);
            wake_pulse_q <= (state_q == ST_DEEP) && ev;
        end
    end

    assign idle       = idle_q;
    assign interrupt  = interrupt_q;
    assign wake_pulse = wake_pulse_q;
    assign state      = state_q;

endmodule

// File: tb/tb_idle_monitor.sv
// Directed bench for idle_monitor: default config plus a narrow saturating config
// and an IDLE_THRESH=1 config, all sharing the same stimulus.
module tb_idle_monitor;

    logic clk = 1'b0;
    logic reset_n, activity, wake_req, pg_down;

    logic        idle1, int1, wp1;
    logic [15:0] cnt1;
    logic [1:0]  st1;
    logic        idle2, int2, wp2;
    logic [3:0]  cnt2;
    logic [1:0]  st2;
    logic        idle3, int3, wp3;
    logic [1:0]  cnt3;
    logic [1:0]  st3;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    idle_monitor dut (
        .clk(clk), .reset_n(reset_n), .activity(activity), .wake_req(wake_req),
        .pg_down(pg_down), .idle(idle1), .interrupt(int1), .wake_pulse(wp1),
        .idle_cnt(cnt1), .state(st1)
    );

    idle_monitor #(.IDLE_THRESH(4), .DEEP_THRESH(15), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .activity(activity), .wake_req(wake_req),
        .pg_down(pg_down), .idle(idle2), .interrupt(int2), .wake_pulse(wp2),
        .idle_cnt(cnt2), .state(st2)
    );

    idle_monitor #(.IDLE_THRESH(1), .DEEP_THRESH(2), .CNT_W(2)) dut_one (
        .clk(clk), .reset_n(reset_n), .activity(activity), .wake_req(wake_req),
        .pg_down(pg_down), .idle(idle3), .interrupt(int3), .wake_pulse(wp3),
        .idle_cnt(cnt3), .state(st3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic seen_idle;
        reset_n  = 1'b0;
        activity = 1'b0;
        wake_req = 1'b0;
        pg_down  = 1'b0;
        tick(2);
        chk("rst_state", st1, 0);
        chk("rst_idle", idle1, 0);
        chk("rst_int", int1, 0);
        chk("rst_wp", wp1, 0);
        chk("rst_cnt", cnt1, 0);

        // Quiet run from reset: first edge is ordinary, idle at edge 8.
        reset_n = 1'b1;
        tick();
        chk("q1_state", st1, 1);
        chk("q1_cnt", cnt1, 1);
        tick(6);
        chk("q7_idle", idle1, 0);
        tick();
        chk("q8_idle", idle1, 1);
        chk("q8_cnt", cnt1, 8);
        chk("q8_state", st1, 2);
        tick(23);
        chk("q31_int", int1, 0);
        tick();
        chk("q32_int", int1, 1);
        chk("q32_state", st1, 3);
        chk("q32_cnt", cnt1, 32);

        // Powered down: activity ignored, wake_req exits with one pulse.
        pg_down  = 1'b1;
        activity = 1'b1;
        tick();
        chk("pgd_act_state", st1, 3);
        chk("pgd_act_cnt", cnt1, 33);
        chk("pgd_act_wp", wp1, 0);
        activity = 1'b0;
        wake_req = 1'b1;
        tick();
        chk("wake_state", st1, 0);
        chk("wake_idle", idle1, 0);
        chk("wake_int", int1, 0);
        chk("wake_wp", wp1, 1);
        chk("wake_cnt", cnt1, 0);
        wake_req = 1'b0;
        tick();
        chk("wake_wp_once", wp1, 0);
        chk("post_wake_state", st1, 1);
        pg_down = 1'b0;

        // 7 quiet cycles then activity: idle never asserts.
        activity = 1'b1;
        tick();
        activity  = 1'b0;
        seen_idle = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen_idle |= idle1;
        end
        chk("q7_no_idle", seen_idle, 0);
        activity = 1'b1;
        tick();
        chk("q7_act_cnt", cnt1, 0);
        chk("q7_act_state", st1, 0);

        // Activity on the edge the threshold would be reached: activity wins.
        activity = 1'b0;
        tick(7);
        activity = 1'b1;
        tick();
        chk("tie_state", st1, 0);
        chk("tie_idle", idle1, 0);
        chk("tie_cnt", cnt1, 0);

        // wake_req alone while counting clears the count.
        activity = 1'b0;
        tick(3);
        wake_req = 1'b1;
        tick();
        chk("wreq_cnt", cnt1, 0);
        chk("wreq_state", st1, 0);
        wake_req = 1'b0;
        activity = 1'b1;
        tick();

        // Narrow counter saturates at 15 and stays in DEEP.
        activity = 1'b0;
        tick(4);
        chk("sat_q4_idle", idle2, 1);
        tick(11);
        chk("sat_q15_int", int2, 1);
        tick(25);
        chk("sat_cnt", cnt2, 15);
        chk("sat_state", st2, 3);
        chk("q40_cnt", cnt1, 40);
        chk("q40_state", st1, 3);

        // Asynchronous reset between edges while in DEEP.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_idle", idle1, 0);
        chk("arst_int", int1, 0);
        chk("arst_cnt", cnt1, 0);
        chk("arst_state", st1, 0);
        chk("arst_wp", wp1, 0);
        tick();
        chk("arst_wp_edge", wp1, 0);

        // IDLE_THRESH=1 skips COUNTING.
        reset_n = 1'b1;
        tick();
        chk("one_state", st3, 2);
        chk("one_idle", idle3, 1);
        chk("one_wp_after_rst", wp1, 0);
        tick();
        chk("one_deep", st3, 3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
